// File: rtl/y86_pkg.sv
// Shared definitions for the Y86 memory port arbiter: FSM encoding,
// memory size default and instruction/word lengths in bytes.
package y86_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    F_BEAT0 = 2'd1,
    F_BEAT1 = 2'd2,
    M_ACC   = 2'd3
  } arb_state_t;

  localparam logic [63:0] MEM_LIMIT_DEFAULT = 64'h0000_0000_0000_2000;
  localparam int          INSTR_LEN         = 10;
  localparam int          WORD_LEN          = 8;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and memory-stage requests onto one single-port memory.
// Fetches take two 8-byte beats; data accesses take one.
module mem_port_arbiter
  import y86_pkg::*;
#(
  parameter logic [63:0] MEM_LIMIT = MEM_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [63:0] f_addr,
  output logic        f_done,
  output logic [79:0] f_instr,
  output logic        imem_error,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [63:0] m_addr,
  input  logic [63:0] m_wdata,
  output logic        m_done,
  output logic [63:0] m_rdata,
  output logic        dmem_error,
  output logic        f_busy,
  output logic        m_busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  input  logic        mem_err
);

  localparam logic [64:0] F_SPAN = 65'(INSTR_LEN);
  localparam logic [64:0] M_SPAN = 65'(WORD_LEN);
  localparam logic [63:0] BEAT1_OFS = 64'(WORD_LEN);

  arb_state_t  state, state_next;
  logic        last_data;
  logic [63:0] f_addr_q, m_addr_q, m_wdata_q, beat0;
  logic        m_we_q;
  logic        f_oob, m_oob, grant_f, grant_m;

  // 65-bit sums so that addresses near 2^64 cannot wrap into range
  assign f_oob  = ({1'b0, f_addr} + F_SPAN) > {1'b0, MEM_LIMIT};
  assign m_oob  = ({1'b0, m_addr} + M_SPAN) > {1'b0, MEM_LIMIT};
  assign f_busy = f_req & ~f_done;
  assign m_busy = m_req & ~m_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // No grant while a done pulse is out: the requester has not yet dropped req
  always_comb begin
    grant_f = 1'b0;
    grant_m = 1'b0;
    if (state == IDLE && !f_done && !m_done) begin
      if (f_req && m_req) begin
        grant_m = ~last_data;
        grant_f = last_data;
      end else begin
        grant_f = f_req;
        grant_m = m_req;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_f && !f_oob)      state_next = F_BEAT0;
        else if (grant_m && !m_oob) state_next = M_ACC;
      end
      F_BEAT0: if (mem_ack) state_next = mem_err ? IDLE : F_BEAT1;
      F_BEAT1: if (mem_ack) state_next = IDLE;
      M_ACC:   if (mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      F_BEAT0: begin
        mem_req  = 1'b1;
        mem_addr = f_addr_q;
      end
      F_BEAT1: begin
        mem_req  = 1'b1;
        mem_addr = f_addr_q + BEAT1_OFS;
      end
      M_ACC: begin
        mem_req   = 1'b1;
        mem_we    = m_we_q;
        mem_addr  = m_addr_q;
        mem_wdata = m_wdata_q;
      end
      default: ;
    endcase
  end

  // Request fields are latched at grant so a dropped request still completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_data  <= 1'b0;
      f_addr_q   <= '0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      m_we_q     <= 1'b0;
      beat0      <= '0;
      f_done     <= 1'b0;
      m_done     <= 1'b0;
      f_instr    <= '0;
      m_rdata    <= '0;
      imem_error <= 1'b0;
      dmem_error <= 1'b0;
    end else begin
      f_done <= 1'b0;
      m_done <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_f) begin
            last_data <= 1'b0;
            f_addr_q  <= f_addr;
            if (f_oob) begin
              f_done     <= 1'b1;
              imem_error <= 1'b1;
            end
          end
          if (grant_m) begin
            last_data <= 1'b1;
            m_addr_q  <= m_addr;
            m_wdata_q <= m_wdata;
            m_we_q    <= m_we;
            if (m_oob) begin
              m_done     <= 1'b1;
              dmem_error <= 1'b1;
            end
          end
        end
        F_BEAT0: begin
          if (mem_ack) begin
            beat0 <= mem_rdata;
            if (mem_err) begin
              f_done     <= 1'b1;
              imem_error <= 1'b1;
            end
          end
        end
        F_BEAT1: begin
          if (mem_ack) begin
            f_instr    <= {mem_rdata[15:0], beat0};
            f_done     <= 1'b1;
            imem_error <= mem_err;
          end
        end
        M_ACC: begin
          if (mem_ack) begin
            if (!m_we_q) m_rdata <= mem_rdata;
            m_done     <= 1'b1;
            dmem_error <= mem_err;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a simple
// latency-configurable memory responder.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_req, f_done, imem_error;
  logic [63:0] f_addr;
  logic [79:0] f_instr;
  logic        m_req, m_we, m_done, dmem_error;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic        f_busy, m_busy;
  logic        mem_req, mem_we, mem_ack, mem_err;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  int f_done_cnt = 0;
  int m_done_cnt = 0;
  int req_cycles = 0;

  int          ack_lat   = 2;
  bit          resp_en   = 1'b1;
  bit          force_ack = 1'b0;
  logic [63:0] err_addr  = '1;
  logic [63:0] beat_addr[$];
  logic        beat_we[$];
  logic [63:0] beat_wdata[$];

  mem_port_arbiter #(.MEM_LIMIT(64'h2000)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_instr(f_instr),
    .imem_error(imem_error),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_done(m_done), .m_rdata(m_rdata), .dmem_error(dmem_error),
    .f_busy(f_busy), .m_busy(m_busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
    return w;
  endfunction

  function automatic logic [79:0] instr_at(input logic [63:0] a);
    logic [79:0] w;
    for (int i = 0; i < 10; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [79:0] observed,
                             input logic [79:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Memory model: answers after ack_lat cycles of mem_req, logging each beat
  initial begin : responder
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_err = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_err = 1'b0;
      if (force_ack) begin
        mem_ack = 1'b1;
      end else if (resp_en && mem_req) begin
        cnt++;
        if (cnt >= ack_lat) begin
          cnt = 0;
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          mem_err   = (mem_addr == err_addr);
          beat_addr.push_back(mem_addr);
          beat_we.push_back(mem_we);
          beat_wdata.push_back(mem_wdata);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (f_done)  f_done_cnt++;
    if (m_done)  m_done_cnt++;
    if (mem_req) req_cycles++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input bit fetch, input logic [63:0] addr,
                               input bit we, input logic [63:0] wdata);
    if (fetch) begin
      f_req  = 1'b1;
      f_addr = addr;
    end else begin
      m_req   = 1'b1;
      m_addr  = addr;
      m_we    = we;
      m_wdata = wdata;
    end
  endtask

  task automatic waitDone(input bit fetch, input string tag);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!(fetch ? f_done : m_done) && n < 200);
    checkOutput({tag, "_done"}, fetch ? f_done : m_done, 1);
    checkOutput({tag, "_busy"}, fetch ? f_busy : m_busy, 0);
    if (fetch) f_req = 1'b0;
    else       m_req = 1'b0;
  endtask

  task automatic runConflict(input string tag, input logic [63:0] fa, input logic [63:0] ma);
    logic [15:0] ord = '0;
    int n = 0;
    applyStimulus(1'b1, fa, 1'b0, '0);
    applyStimulus(1'b0, ma, 1'b0, '0);
    while ((f_req || m_req) && n < 200) begin
      tick(1);
      n++;
      if (m_done && m_req) begin
        ord = {ord[7:0], 8'h4D};
        m_req = 1'b0;
      end
      if (f_done && f_req) begin
        ord = {ord[7:0], 8'h46};
        f_req = 1'b0;
      end
    end
    checkOutput({tag, "_order"}, ord, 16'h4D46);
    checkOutput({tag, "_instr"}, f_instr, instr_at(fa));
    checkOutput({tag, "_rdata"}, m_rdata, mem_word(ma));
    tick(1);
  endtask

  initial begin : main
    int b, c0, r0, n;
    logic [63:0] saved;
    logic [79:0] saved_i;
    f_req = 0; f_addr = 0; m_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
    rst = 1'b0;
    #2 rst = 1'b1;
    tick(2);

    checkOutput("rst_f_done", f_done, 0);
    checkOutput("rst_m_done", m_done, 0);
    checkOutput("rst_f_instr", f_instr, 0);
    checkOutput("rst_m_rdata", m_rdata, 0);
    checkOutput("rst_errors", {imem_error, dmem_error}, 0);
    checkOutput("rst_mem_req", {mem_req, mem_we}, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    tick(1);

    runConflict("conflict1", 64'h180, 64'h200);
    runConflict("conflict2", 64'h1A0, 64'h208);

    // single fetch, two beats
    ack_lat = 2;
    b = beat_addr.size();
    c0 = f_done_cnt;
    applyStimulus(1'b1, 64'h100, 1'b0, '0);
    tick(1);
    checkOutput("fetch_busy", f_busy, 1);
    waitDone(1'b1, "fetch100");
    tick(3);
    checkOutput("fetch100_beats", beat_addr.size() - b, 2);
    checkOutput("fetch100_beat0", beat_addr[b], 64'h100);
    checkOutput("fetch100_beat1", beat_addr[b+1], 64'h108);
    checkOutput("fetch100_instr", f_instr, instr_at(64'h100));
    checkOutput("fetch100_err", imem_error, 0);
    checkOutput("fetch100_pulses", f_done_cnt - c0, 1);

    // out-of-range data access
    saved = m_rdata;
    r0 = req_cycles;
    applyStimulus(1'b0, 64'h1FFC, 1'b0, '0);
    tick(1);
    checkOutput("oob_m_timing", m_done, 1);
    checkOutput("oob_m_err", dmem_error, 1);
    checkOutput("oob_m_rdata", m_rdata, saved);
    m_req = 1'b0;
    tick(2);
    checkOutput("oob_m_noreq", req_cycles - r0, 0);

    applyStimulus(1'b0, 64'h1FF8, 1'b0, '0);
    waitDone(1'b0, "edge_m");
    checkOutput("edge_m_err", dmem_error, 0);
    checkOutput("edge_m_rdata", m_rdata, mem_word(64'h1FF8));
    tick(1);

    // wrapping fetch address must fail the range check
    saved_i = f_instr;
    r0 = req_cycles;
    applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, '0);
    tick(1);
    checkOutput("wrap_f_timing", f_done, 1);
    checkOutput("wrap_f_err", imem_error, 1);
    checkOutput("wrap_f_instr", f_instr, saved_i);
    f_req = 1'b0;
    tick(2);
    checkOutput("wrap_f_noreq", req_cycles - r0, 0);

    ack_lat = 1;
    applyStimulus(1'b1, 64'h1FF6, 1'b0, '0);
    waitDone(1'b1, "edge_f");
    checkOutput("edge_f_err", imem_error, 0);
    checkOutput("edge_f_instr", f_instr, instr_at(64'h1FF6));
    tick(1);

    // bus error on beat 0
    ack_lat = 2;
    err_addr = 64'h300;
    b = beat_addr.size();
    applyStimulus(1'b1, 64'h300, 1'b0, '0);
    waitDone(1'b1, "berr");
    checkOutput("berr_err", imem_error, 1);
    tick(3);
    checkOutput("berr_beats", beat_addr.size() - b, 1);
    err_addr = '1;

    // reset while waiting for the second fetch beat
    b = beat_addr.size();
    applyStimulus(1'b1, 64'h400, 1'b0, '0);
    n = 0;
    while (beat_addr.size() == b && n < 50) begin
      tick(1);
      n++;
    end
    resp_en = 1'b0;
    tick(2);
    checkOutput("rstb1_req", mem_req, 1);
    checkOutput("rstb1_addr", mem_addr, 64'h408);
    rst = 1'b1;
    #1;
    checkOutput("rstb1_mem_req", mem_req, 0);
    checkOutput("rstb1_mem_addr", mem_addr, 0);
    checkOutput("rstb1_instr", f_instr, 0);
    checkOutput("rstb1_rdata", m_rdata, 0);
    checkOutput("rstb1_errors", {imem_error, dmem_error}, 0);
    f_req = 1'b0;
    tick(1);
    rst = 1'b0;
    c0 = f_done_cnt + m_done_cnt;
    force_ack = 1'b1;
    tick(1);
    force_ack = 1'b0;
    tick(3);
    checkOutput("stale_ack_done", f_done_cnt + m_done_cnt - c0, 0);
    checkOutput("stale_ack_req", mem_req, 0);
    resp_en = 1'b1;

    // store leaves load data untouched
    applyStimulus(1'b0, 64'h48, 1'b0, '0);
    waitDone(1'b0, "load48");
    tick(1);
    ack_lat = 3;
    b = beat_addr.size();
    applyStimulus(1'b0, 64'h40, 1'b1, 64'hDEAD);
    n = 0;
    do begin
      tick(1);
      n++;
      if (mem_req) begin
        checkOutput("store_we", mem_we, 1);
        checkOutput("store_wdata", mem_wdata, 64'hDEAD);
      end
    end while (!m_done && n < 200);
    checkOutput("store_done", m_done, 1);
    m_req = 1'b0;
    checkOutput("store_rdata", m_rdata, mem_word(64'h48));
    checkOutput("store_err", dmem_error, 0);
    checkOutput("store_beats", beat_addr.size() - b, 1);
    if (beat_addr.size() > b) begin
      checkOutput("store_log_addr", beat_addr[b], 64'h40);
      checkOutput("store_log_we", beat_we[b], 1);
      checkOutput("store_log_wdata", beat_wdata[b], 64'hDEAD);
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: observed no completion, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter MEM_LIMIT, default 64'h0000_0000_0000_2000; first invalid byte address.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port f_req  input  1  fetch-stage instruction read request; held until f_done.
REQ-005 SHALL have port f_addr  input  64  PC byte address; stable while f_req is high.
REQ-006 SHALL have port f_done  output  1  one-cycle pulse: instruction ready or error.
REQ-007 SHALL have port f_instr  output  80  instruction bytes, byte 0 in [7:0].
REQ-008 SHALL have port imem_error  output  1  valid with f_done; fetch address or bus error.
REQ-009 SHALL have port m_req, m_we  input  1 each  memory-stage request and write enable; held until m_done.
REQ-010 SHALL have port m_addr, m_wdata  input  64 each  data address and store data; stable while m_req is high.
REQ-011 SHALL have port m_done  output  1  one-cycle completion pulse.
REQ-012 SHALL have port m_rdata  output  64  load data, valid with m_done.
REQ-013 SHALL have port dmem_error  output  1  valid with m_done.
REQ-014 SHALL have port f_busy, m_busy  output  1 each  combinational: req high and done low; feed pipeline stall logic.
REQ-015 SHALL have ports mem_req  output  1, mem_we  output  1, mem_addr  output  64, mem_wdata  output  64  single-port memory request.
REQ-016 SHALL have ports mem_ack  input  1, mem_rdata  input  64, mem_err  input  1  memory response; rdata and err valid with ack.

Function
REQ-017 SHALL implement FSM states IDLE, F_BEAT0, F_BEAT1, M_ACC.
REQ-018 SHALL, in IDLE with only one request pending, grant it in the next cycle.
REQ-019 SHALL, in IDLE with both requests pending, grant the requester not granted last; the last-grant flag resets to fetch, so data wins the first conflict.
REQ-020 SHALL check address range before issue: fetch fails if f_addr+10 > MEM_LIMIT; data fails if m_addr+8 > MEM_LIMIT; no memory request is issued, and done pulses the cycle after grant with error=1.
REQ-021 SHALL, in F_BEAT0, drive mem_req=1, mem_we=0, mem_addr=f_addr until mem_ack, then capture mem_rdata as bytes 0-7 and go to F_BEAT1.
REQ-022 SHALL, in F_BEAT1, drive mem_addr=f_addr+8 and, on mem_ack, set f_instr={mem_rdata[15:0],beat0}, pulse f_done the same cycle, and return to IDLE.
REQ-023 SHALL, in M_ACC, drive mem_req=1, mem_we=m_we, mem_addr=m_addr, mem_wdata=m_wdata; on mem_ack, latch m_rdata (unchanged for stores), pulse m_done, return to IDLE.
REQ-024 SHALL OR mem_err over both fetch beats into imem_error; on a beat-0 error, skip beat 1 and finish immediately.
REQ-025 SHALL keep mem_req low in IDLE; minimum gap between consecutive transactions is one IDLE cycle.
REQ-026 SHALL complete a started transaction even if its request drops; the done pulse is still produced.
REQ-027 SHALL hold f_instr, m_rdata and both error flags between done pulses.
REQ-028 SHALL use 64-bit wrap-around for f_addr+8; the range check in REQ-020 uses 65-bit arithmetic so wrapped addresses fail.

Reset
REQ-029 SHALL, on rst, immediately force state IDLE, last-grant=fetch, mem_req=0, mem_we=0, done pulses 0, f_instr=0, m_rdata=0, errors 0, mem_addr=0, mem_wdata=0.
REQ-030 SHALL discard an in-flight transaction on rst; a mem_ack arriving in IDLE is ignored.

Structure
REQ-031 SHALL place state encoding, MEM_LIMIT default, and instruction-length (10) and word-length (8) constants in shared package y86_pkg.
REQ-032 SHALL be a single module; a separate sub-module is not required.

Verification
REQ-033 Single fetch, f_addr=0x100, ack latency 2 -> two mem_req beats at 0x100/0x108; f_done asserted once; f_instr = bytes 0x100-0x109.
REQ-034 f_req and m_req both rise in the same cycle after reset -> data served first, then fetch; second conflict -> data granted, fetch granted before it.
REQ-035 m_addr=0x1FFC, MEM_LIMIT=0x2000 -> no mem_req; m_done with dmem_error=1 one cycle after grant.
REQ-036 mem_err on fetch beat 0 -> no beat 1; f_done with imem_error=1.
REQ-037 rst asserted while in F_BEAT1 waiting for ack -> outputs zero, state IDLE; a later stale mem_ack produces no done pulse.
REQ-038 Store m_we=1, m_addr=0x40, m_wdata=0xDEAD -> mem_we=1, mem_wdata=0xDEAD held until ack; m_rdata unchanged.
